// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and load/store ports.
// Data accesses win; a starve counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [2:0]            d_write_sections,
    output logic [31:0]           d_rdata,
    output logic                  d_valid,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [2:0]            mem_write_sections,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_r, state_next_s;
    logic                  grant_d_s, grant_i_s;
    logic                  owner_d_r, owner_d_s;
    logic [2:0]            lat_cnt_r, lat_cnt_s;
    logic [3:0]            starve_r, starve_s;
    logic [31:0]           if_rdata_r, if_rdata_s;
    logic [31:0]           d_rdata_r, d_rdata_s;
    logic                  if_valid_r, if_valid_s;
    logic                  d_valid_r, d_valid_s;
    logic                  mem_en_r, mem_en_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]           mem_wdata_r, mem_wdata_s;
    logic [2:0]            mem_ws_r, mem_ws_s;

    // Grant selection: data first unless fetch has waited through STARVE_LIMIT data grants.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
            grant_d_s = d_req && (!if_req || (starve_r < STARVE_MAX));
            grant_i_s = if_req && !grant_d_s;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = (grant_d_s || grant_i_s) ? ISSUE : IDLE;
            ISSUE:   state_next_s = (mem_ws_r != 3'b000) ? RESP : WAIT;
            WAIT:    state_next_s = (lat_cnt_r == 3'd0) ? RESP : WAIT;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and counters.
    always_comb begin
        owner_d_s   = owner_d_r;
        lat_cnt_s   = lat_cnt_r;
        starve_s    = starve_r;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_valid_s  = 1'b0;
        d_valid_s   = 1'b0;
        mem_en_s    = 1'b0;
        mem_ws_s    = 3'b000;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    owner_d_s   = 1'b1;
                    mem_en_s    = 1'b1;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                    mem_ws_s    = d_write_sections;
                    if (if_req) begin
                        starve_s = (starve_r < STARVE_MAX) ? (starve_r + 4'd1) : starve_r;
                    end else begin
                        starve_s = 4'd0;
                    end
                end else if (grant_i_s) begin
                    owner_d_s   = 1'b0;
                    mem_en_s    = 1'b1;
                    mem_addr_s  = if_addr;
                    mem_wdata_s = 32'd0;
                    mem_ws_s    = 3'b000;
                    starve_s    = 4'd0;
                end else begin
                    mem_en_s = 1'b0;
                end
            end
            ISSUE: begin
                // Writes complete without waiting for the memory; reads arm the latency counter.
                if (mem_ws_r != 3'b000) begin
                    d_valid_s  = owner_d_r;
                    if_valid_s = !owner_d_r;
                end else begin
                    lat_cnt_s = LAT_INIT;
                end
            end
            WAIT: begin
                if (lat_cnt_r == 3'd0) begin
                    if (owner_d_r) begin
                        d_rdata_s = mem_rdata;
                        d_valid_s = 1'b1;
                    end else begin
                        if_rdata_s = mem_rdata;
                        if_valid_s = 1'b1;
                    end
                end else begin
                    lat_cnt_s = lat_cnt_r - 3'd1;
                end
            end
            RESP: begin
                lat_cnt_s = lat_cnt_r;
            end
            default: begin
                lat_cnt_s = 3'd0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_r   <= 1'b0;
            lat_cnt_r   <= 3'd0;
            starve_r    <= 4'd0;
            if_rdata_r  <= 32'd0;
            d_rdata_r   <= 32'd0;
            if_valid_r  <= 1'b0;
            d_valid_r   <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            mem_ws_r    <= 3'b000;
        end else begin
            owner_d_r   <= owner_d_s;
            lat_cnt_r   <= lat_cnt_s;
            starve_r    <= starve_s;
            if_rdata_r  <= if_rdata_s;
            d_rdata_r   <= d_rdata_s;
            if_valid_r  <= if_valid_s;
            d_valid_r   <= d_valid_s;
            mem_en_r    <= mem_en_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_ws_r    <= mem_ws_s;
        end
    end

    assign if_rdata           = if_rdata_r;
    assign if_valid           = if_valid_r;
    assign d_rdata            = d_rdata_r;
    assign d_valid            = d_valid_r;
    assign mem_en             = mem_en_r;
    assign mem_addr           = mem_addr_r;
    assign mem_wdata          = mem_wdata_r;
    assign mem_write_sections = mem_ws_r;

endmodule
